// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the CPU control unit: instruction op field values,
// system-function codes, branch condition codes, the two pass-through ALU
// operations and the control FSM state type. Also provides the branch
// condition evaluator used by the decoder.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Op field IR[15:13]; 3'b110 and 3'b111 are undefined
    localparam logic [2:0] OP_SYS = 3'b000;
    localparam logic [2:0] OP_ALU = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b010;
    localparam logic [2:0] OP_ST  = 3'b011;
    localparam logic [2:0] OP_BCC = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;

    // Function field values that are defined under OP_SYS
    localparam logic [3:0] F_NOP  = 4'h0;
    localparam logic [3:0] F_HALT = 4'hF;

    // Branch condition field IR[10:8]
    localparam logic [2:0] COND_AL  = 3'b000;
    localparam logic [2:0] COND_Z   = 3'b001;
    localparam logic [2:0] COND_NZ  = 3'b010;
    localparam logic [2:0] COND_N   = 3'b011;
    localparam logic [2:0] COND_NN  = 3'b100;
    localparam logic [2:0] COND_C   = 3'b101;
    localparam logic [2:0] COND_NC  = 3'b110;
    localparam logic [2:0] COND_ILL = 3'b111;

    // ALU operations that route one operand straight through
    localparam logic [3:0] ALU_PASS_R = 4'hE;
    localparam logic [3:0] ALU_PASS_S = 4'hF;

    // Control FSM states; ST_STALL is only reachable in single-step builds
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5,
        ST_STALL  = 3'd6
    } cpu_state_t;

    // Evaluates a branch condition against the {n,z,c} flags
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
        logic n, z, c;
        n = flags[2];
        z = flags[1];
        c = flags[0];
        case (cond)
            COND_AL: return 1'b1;
            COND_Z:  return z;
            COND_NZ: return !z;
            COND_N:  return n;
            COND_NN: return !n;
            COND_C:  return c;
            COND_NC: return !c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_cu_decode.sv
// -----------------------------------------------------------------------------
// cpu_cu_decode
// Purely combinational instruction classifier. Looks only at the upper byte
// of the instruction register (op, function and condition fields) and reports
// which instruction class is present and whether a branch is taken.
//
// Ports:
//   ir_hi       in  8  IR[15:8]
//   alu_status  in  3  {n,z,c} flags from the execution unit
//   is_halt     out 1  OP_SYS with F_HALT
//   is_illegal  out 1  undefined op, undefined SYS function or cond 111
//   is_alu      out 1  ALU register-register operation
//   is_ld       out 1  load
//   is_st       out 1  store
//   is_jmp      out 1  register-indirect jump
//   take_branch out 1  conditional branch whose condition holds
// -----------------------------------------------------------------------------
module cpu_cu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir_hi,
    input  logic [2:0] alu_status,
    output logic       is_halt,
    output logic       is_illegal,
    output logic       is_alu,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_jmp,
    output logic       take_branch
);

    logic [2:0] op;
    logic [3:0] f;
    logic [2:0] cond;

    assign op   = ir_hi[7:5];
    assign f    = ir_hi[4:1];
    assign cond = ir_hi[2:0];

    // Classify the instruction; a NOP or an untaken branch leaves every
    // output low, which the FSM treats as "back to fetch".
    always_comb begin
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        is_alu      = 1'b0;
        is_ld       = 1'b0;
        is_st       = 1'b0;
        is_jmp      = 1'b0;
        take_branch = 1'b0;
        case (op)
            OP_SYS: begin
                if (f == F_HALT)
                    is_halt = 1'b1;
                else if (f != F_NOP)
                    is_illegal = 1'b1;
            end
            OP_ALU: is_alu = 1'b1;
            OP_LD:  is_ld  = 1'b1;
            OP_ST:  is_st  = 1'b1;
            OP_BCC: begin
                if (cond == COND_ILL)
                    is_illegal = 1'b1;
                else
                    take_branch = cond_met(cond, alu_status);
            end
            OP_JMP: is_jmp = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// -----------------------------------------------------------------------------
// cpu_cu
// Control unit for the CPU execution unit. A fetch/decode/execute FSM that
// drives every execution-unit control line and owns the memory req/ack
// handshake, so any number of memory wait states is tolerated.
//
// Build option: CPU_CU_SINGLE_STEP_EN adds a 'step' input and a STALL state
// that every return to FETCH passes through; the core then advances one
// instruction per sampled step=1.
//
// Ports:
//   clock       in  1   system clock, rising edge
//   reset       in  1   asynchronous, active-low reset
//   step        in  1   (single-step builds only) release from STALL
//   IR          in  16  instruction register contents
//   alu_status  in  3   {n,z,c} flags
//   mem_ack     in  1   memory completes the current request this cycle
//   ir_ld, pc_inc, pc_ld, pc_sel, reg_we, adr_sel, s_sel
//               out 1   execution-unit controls
//   w_adr, r_adr, s_adr out 3  register addresses (IR[8:6], IR[5:3], IR[2:0])
//   alu_op      out 4   ALU operation
//   mem_req     out 1   memory request, held until mem_ack
//   mem_we      out 1   write qualifier for mem_req
//   halted      out 1   core stopped
//   illegal     out 1   sticky: stopped on an undefined opcode
// -----------------------------------------------------------------------------
module cpu_cu
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
`ifdef CPU_CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] IR,
    input  logic [2:0]  alu_status,
    input  logic        mem_ack,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        reg_we,
    output logic        adr_sel,
    output logic        s_sel,
    output logic [2:0]  w_adr,
    output logic [2:0]  r_adr,
    output logic [2:0]  s_adr,
    output logic [3:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        illegal
);

`ifdef CPU_CU_SINGLE_STEP_EN
    localparam cpu_state_t FETCH_ENTRY = ST_STALL;
`else
    localparam cpu_state_t FETCH_ENTRY = ST_FETCH;
`endif

    cpu_state_t state, state_nxt;

    logic is_halt, is_illegal, is_alu, is_ld, is_st, is_jmp, take_branch;

    cpu_cu_decode u_decode (
        .ir_hi       (IR[15:8]),
        .alu_status  (alu_status),
        .is_halt     (is_halt),
        .is_illegal  (is_illegal),
        .is_alu      (is_alu),
        .is_ld       (is_ld),
        .is_st       (is_st),
        .is_jmp      (is_jmp),
        .take_branch (take_branch)
    );

    assign w_adr  = IR[8:6];
    assign r_adr  = IR[5:3];
    assign s_adr  = IR[2:0];
    assign halted = (state == ST_HALT);

    // State register plus the sticky illegal flag. The flag is set on the
    // same edge that moves DECODE into HALT, so it is valid in the first
    // halted cycle; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE && is_illegal)
                illegal <= 1'b1;
        end
    end

    // Next-state selection. Every return to fetch goes through FETCH_ENTRY
    // so the single-step build can interpose its STALL state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = FETCH_ENTRY;
            ST_FETCH: if (mem_ack) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (is_halt || is_illegal)
                    state_nxt = ST_HALT;
                else if (is_alu || is_jmp)
                    state_nxt = ST_EXEC;
                else if (is_ld || is_st)
                    state_nxt = ST_MEM;
                else
                    state_nxt = FETCH_ENTRY;
            end
            ST_EXEC:  state_nxt = FETCH_ENTRY;
            ST_MEM:   if (mem_ack) state_nxt = FETCH_ENTRY;
            ST_HALT:  state_nxt = ST_HALT;
`ifdef CPU_CU_SINGLE_STEP_EN
            ST_STALL: if (step) state_nxt = ST_FETCH;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs decoded from state and IR. Controls that commit a
    // memory result (ir_ld, pc_inc, LD's reg_we/s_sel) are qualified by
    // mem_ack so wait cycles leave the datapath untouched. Because the
    // state resets asynchronously to IDLE, all controls drop at once.
    always_comb begin
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        pc_sel  = 1'b0;
        reg_we  = 1'b0;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        alu_op  = 4'h0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_ld   = mem_ack;
                pc_inc  = mem_ack;
            end
            ST_DECODE: begin
                pc_ld = take_branch;
            end
            ST_EXEC: begin
                if (is_alu) begin
                    alu_op = IR[12:9];
                    reg_we = 1'b1;
                end else if (is_jmp) begin
                    alu_op = ALU_PASS_R;
                    pc_sel = 1'b1;
                    pc_ld  = 1'b1;
                end
            end
            ST_MEM: begin
                adr_sel = 1'b1;
                mem_req = 1'b1;
                alu_op  = ALU_PASS_S;
                if (is_ld) begin
                    reg_we = mem_ack;
                    s_sel  = mem_ack;
                end else begin
                    mem_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_cu.md
# cpu_cu

Control unit that sequences the CPU execution unit. Runs a fetch/decode/execute state machine over the 16-bit instruction register and drives every execution-unit control line: IR load, PC increment/load/select, register write, address and S-operand muxes, register addresses and ALU opcode. Owns the memory request/acknowledge handshake, so fetches and loads/stores tolerate any number of wait states.

## Interface
- No parameters. Widths are fixed by the execution unit.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IR  in  16  instruction register contents from the execution unit
- alu_status  in  3  {n,z,c} flags from the execution unit
- mem_ack  in  1  memory completes the current request this cycle
- ir_ld, pc_inc, pc_ld, pc_sel, reg_we, adr_sel, s_sel  out  1 each  execution-unit controls
- w_adr, r_adr, s_adr  out  3 each  register addresses
- alu_op  out  4  ALU operation
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req (store)
- halted  out  1  core stopped (HALT or illegal opcode)
- illegal  out  1  sticky: stopped on an undefined opcode

## Operation
- Fields: op=IR[15:13], f=IR[12:9], W=IR[8:6], R=IR[5:3], S=IR[2:0], cond=IR[10:8], off=IR[7:0].
- w_adr=W, r_adr=R, s_adr=S are driven straight from IR in every state.
- op 000: f=0000 is NOP. f=1111 is HALT. Any other f is illegal.
- op 001 ALU: R[W] <= R[R] f R[S]. alu_op=f, s_sel=0, reg_we in EXEC.
- op 010 LD: R[W] <= M[R[R]]. adr_sel=1, mem_req; s_sel=1, alu_op=ALU_PASS_S, reg_we on the mem_ack cycle.
- op 011 ST: M[R[R]] <= R[S]. adr_sel=1, mem_req, mem_we=1, alu_op=ALU_PASS_S (D_out=R[S]).
- op 100 Bcc: if the condition holds, PC <= PC+sext(off) (pc_sel=0, pc_ld=1) in DECODE. PC is already incremented at that point.
  - cond 000: always
  - cond 001: z
  - cond 010: !z
  - cond 011: n
  - cond 100: !n
  - cond 101: c
  - cond 110: !c
  - cond 111: illegal
- op 101 JMP: PC <= R[R]. alu_op=ALU_PASS_R, pc_sel=1, pc_ld=1 in EXEC.
- op 110 and op 111 are illegal.
- States:
  - IDLE -> FETCH unconditionally.
  - FETCH: adr_sel=0, mem_req=1. On mem_ack, assert ir_ld=1 and pc_inc=1 in the same cycle -> DECODE. Otherwise stay in FETCH.
  - DECODE:
    - NOP or untaken Bcc -> FETCH.
    - Taken Bcc: pc_ld -> FETCH.
    - ALU or JMP -> EXEC.
    - LD or ST -> MEM.
    - HALT or illegal -> HALT.
  - EXEC: perform the ALU write or the JMP load -> FETCH.
  - MEM: hold mem_req until mem_ack, then -> FETCH.
  - HALT: terminal; halted=1. illegal=1 if it was entered on an undefined opcode.
- Control outputs are decoded from state and IR. ir_ld, pc_inc and LD's reg_we also depend on mem_ack, and are asserted only in the mem_ack cycle.
- Outside the active state, every control output is 0. alu_op defaults to 4'h0.

## Timing
- Reset value: state=IDLE, illegal=0, and every output 0. Outputs fall to 0 immediately when reset asserts (asynchronous).
- Reset asserted mid-request drops mem_req at once. The instruction in flight is abandoned, with no partial register or PC write.
- First mem_req is asserted in the second cycle after reset release.
- Cycles per instruction with zero-wait memory (mem_ack in the first request cycle):
  - NOP or Bcc: 2
  - ALU or JMP: 3
  - LD or ST: 3
- Each wait cycle adds exactly 1 cycle.
- mem_ack while mem_req=0 is ignored.
- mem_req never drops before mem_ack, except on reset.
- Branch flags are sampled in DECODE and reflect the previous ALU result.
- Offset wraps modulo 2^16.

## Configuration
- CPU_CU_SINGLE_STEP_EN defined:
  - Adds input step (1 bit) and state STALL.
  - Every path that would enter FETCH goes to STALL instead, with all outputs 0.
  - STALL -> FETCH in the cycle after step=1 is sampled. step held high advances one instruction per STALL visit.
  - IDLE also goes to STALL.
- Undefined: no step port and no STALL state; the core free-runs.

## Structure
- Package cpu_pkg holds:
  - the op field encodings (OP_SYS, OP_ALU, OP_LD, OP_ST, OP_BCC, OP_JMP)
  - the cond encodings
  - ALU_PASS_R=4'hE and ALU_PASS_S=4'hF
  - the state enum
- One sub-module, cpu_cu_decode: combinational IR-to-control decode plus condition evaluation. The FSM stays in cpu_cu.

## Test plan
- Reset release with mem_ack tied 1 -> mem_req rises in cycle 2. IR=16'h0000 gives 2-cycle NOP loops, pc_inc pulsing every 2 cycles.
- ALU IR=16'h2253 (f=1, W=1, R=2, S=3) -> EXEC cycle shows alu_op=1, reg_we=1, w_adr=1, r_adr=2, s_adr=3, s_sel=0.
- LD with mem_ack delayed 3 cycles -> mem_req and adr_sel held for 4 cycles, reg_we and s_sel=1 only in the ack cycle, alu_op=4'hF.
- Bcc cond=001 off=8'hFC: z=1 -> pc_ld=1, pc_sel=0 in DECODE. z=0 -> no pc_ld, next state FETCH.
- IR=16'hC000 -> halted=1, illegal=1, mem_req stays 0 for 20 cycles. Reset restarts the core and clears illegal.
- Reset asserted during a FETCH wait -> mem_req=0 in the same cycle, no ir_ld. With CPU_CU_SINGLE_STEP_EN, no fetch until step=1.
